// File: rtl/key_debounce_if.sv
// Key debouncer bundle: raw key levels in, debounced state and event pulses out.
// The debouncer sits on the slave side; the producer of raw key levels is the master.
interface key_debounce_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] key_i;
  logic [NUM_KEYS-1:0] key_state;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] key_long;
  logic [NUM_KEYS-1:0] key_repeat;

  modport master (
    output key_i,
    input  key_state, key_press, key_release, key_long, key_repeat
  );

  modport slave (
    input  key_i,
    output key_state, key_press, key_release, key_long, key_repeat
  );
endinterface

// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer with press/release/long-press/auto-repeat events.
// Each channel owns a 3-flop synchronizer, a debounce counter, a hold counter and a small FSM.
module key_debounce_multi #(
  parameter int NUM_KEYS    = 4,
  parameter int CLK_FREQ    = 100_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic           clk,
  input  logic           rst,
  key_debounce_if.slave  bus
);

  localparam int CYC_PER_MS = CLK_FREQ / 1000;
  localparam int DEB_RAW    = CYC_PER_MS * DEBOUNCE_MS;
  localparam int DEB_CYC    = (DEB_RAW < 1) ? 1 : DEB_RAW;
  localparam int LONG_CYC   = CYC_PER_MS * LONG_MS;
  // Repeat only exists after a long-press, so no long-press means no repeat either.
  localparam int REP_CYC    = (LONG_CYC == 0) ? 0 : CYC_PER_MS * REPEAT_MS;
  localparam int DEB_W      = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC);
  localparam int HOLD_MAX   = (LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC;
  localparam int HOLD_W     = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX);

  localparam bit                LONG_EN   = (LONG_CYC != 0);
  localparam bit                REP_EN    = (REP_CYC != 0);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
  localparam logic [DEB_W-1:0]  DEB_ZERO  = {DEB_W{1'b0}};
  localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYC - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REP_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic              IDLE_LVL  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } state_e;

  logic [NUM_KEYS-1:0] state_v;
  logic [NUM_KEYS-1:0] press_v;
  logic [NUM_KEYS-1:0] release_v;
  logic [NUM_KEYS-1:0] long_v;
  logic [NUM_KEYS-1:0] repeat_v;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    logic [2:0]        sync_r;
    logic [DEB_W-1:0]  deb_cnt_r;
    logic              level_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_nxt;
    state_e            state_r;
    state_e            state_nxt;
    logic              press_r, release_r, long_r, repeat_r;
    logic              press_nxt, release_nxt, long_nxt, repeat_nxt;
    logic              p_s, differ_s, accept_s, press_acc_s, release_acc_s;
    logic              long_hit_s, rep_hit_s;

    assign p_s           = sync_r[2] ^ IDLE_LVL;
    assign differ_s      = (p_s != level_r);
    assign accept_s      = differ_s && (deb_cnt_r == DEB_LAST);
    assign press_acc_s   = accept_s && !level_r;
    assign release_acc_s = accept_s && level_r;
    assign long_hit_s    = LONG_EN && (state_r == ST_HELD) && (hold_cnt_r == LONG_LAST);
    assign rep_hit_s     = REP_EN && (state_r == ST_LONG) && (hold_cnt_r == REP_LAST);

    // Synchronizer and debounce window; any agreeing sample restarts the window.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_r    <= {3{IDLE_LVL}};
        deb_cnt_r <= DEB_ZERO;
        level_r   <= 1'b0;
      end else begin
        sync_r <= {sync_r[1:0], bus.key_i[g]};
        if (!differ_s) begin
          deb_cnt_r <= DEB_ZERO;
        end else if (accept_s) begin
          deb_cnt_r <= DEB_ZERO;
          level_r   <= p_s;
        end else begin
          deb_cnt_r <= deb_cnt_r + DEB_ONE;
        end
      end
    end

    // FSM state, hold counter and registered event pulses.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_r    <= ST_IDLE;
        hold_cnt_r <= HOLD_ZERO;
        press_r    <= 1'b0;
        release_r  <= 1'b0;
        long_r     <= 1'b0;
        repeat_r   <= 1'b0;
      end else begin
        state_r    <= state_nxt;
        hold_cnt_r <= hold_cnt_nxt;
        press_r    <= press_nxt;
        release_r  <= release_nxt;
        long_r     <= long_nxt;
        repeat_r   <= repeat_nxt;
      end
    end

    // Next-state and hold-counter logic; release acceptance always wins.
    always_comb begin
      state_nxt    = state_r;
      hold_cnt_nxt = hold_cnt_r;
      case (state_r)
        ST_IDLE: begin
          if (press_acc_s) begin
            state_nxt    = ST_HELD;
            hold_cnt_nxt = HOLD_ZERO;
          end else begin
            hold_cnt_nxt = HOLD_ZERO;
          end
        end
        ST_HELD: begin
          if (release_acc_s) begin
            state_nxt    = ST_IDLE;
            hold_cnt_nxt = HOLD_ZERO;
          end else if (long_hit_s) begin
            state_nxt    = ST_LONG;
            hold_cnt_nxt = HOLD_ZERO;
          end else if (LONG_EN) begin
            hold_cnt_nxt = hold_cnt_r + HOLD_ONE;
          end else begin
            hold_cnt_nxt = hold_cnt_r;
          end
        end
        ST_LONG: begin
          if (release_acc_s) begin
            state_nxt    = ST_IDLE;
            hold_cnt_nxt = HOLD_ZERO;
          end else if (rep_hit_s) begin
            hold_cnt_nxt = HOLD_ZERO;
          end else if (REP_EN) begin
            hold_cnt_nxt = hold_cnt_r + HOLD_ONE;
          end else begin
            hold_cnt_nxt = hold_cnt_r;
          end
        end
        default: begin
          state_nxt    = ST_IDLE;
          hold_cnt_nxt = HOLD_ZERO;
        end
      endcase
    end

    // Event pulses for the next edge; long/repeat are masked by a coincident release.
    always_comb begin
      press_nxt   = press_acc_s;
      release_nxt = release_acc_s;
      if (release_acc_s) begin
        long_nxt   = 1'b0;
        repeat_nxt = 1'b0;
      end else begin
        long_nxt   = long_hit_s;
        repeat_nxt = rep_hit_s;
      end
    end

    assign state_v[g]   = level_r;
    assign press_v[g]   = press_r;
    assign release_v[g] = release_r;
    assign long_v[g]    = long_r;
    assign repeat_v[g]  = repeat_r;
  end

  assign bus.key_state   = state_v;
  assign bus.key_press   = press_v;
  assign bus.key_release = release_v;
  assign bus.key_long    = long_v;
  assign bus.key_repeat  = repeat_v;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi with DEB_CYC=10, LONG_CYC=50, REP_CYC=20.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_key_debounce_multi;
  localparam int NK = 4;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  key_debounce_if #(.NUM_KEYS(NK)) bus ();

  key_debounce_multi #(
    .NUM_KEYS(NK), .CLK_FREQ(10_000), .DEBOUNCE_MS(1),
    .LONG_MS(5), .REPEAT_MS(2), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    bus.key_i  = 4'hF;
    tick(3);
    checks++;
    if ({bus.key_state, bus.key_press, bus.key_release, bus.key_long, bus.key_repeat} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs got state=%b press=%b rel=%b long=%b rep=%b expected all 0",
               bus.key_state, bus.key_press, bus.key_release, bus.key_long, bus.key_repeat);
    end
    rst = 1'b0;
    tick(5);
    checks++;
    if ({bus.key_state, bus.key_press, bus.key_release} !== 12'h0) begin
      errors++;
      $display("FAIL reset_idle got state=%b press=%b rel=%b expected 0", bus.key_state, bus.key_press, bus.key_release);
    end
  endtask

  task automatic test_single_press();
    logic [3:0] exp_st, exp_ev;
    bus.key_i[0] = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      exp_st = (k >= 13) ? 4'b0001 : 4'b0000;
      exp_ev = (k == 13) ? 4'b0001 : 4'b0000;
      checks++;
      if (bus.key_state !== exp_st || bus.key_press !== exp_ev || bus.key_release !== 4'b0000) begin
        errors++;
        $display("FAIL single_press k=%0d got state=%b press=%b rel=%b expected state=%b press=%b rel=0000",
                 k, bus.key_state, bus.key_press, bus.key_release, exp_st, exp_ev);
      end
    end
    bus.key_i[0] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      exp_st = (k >= 13) ? 4'b0000 : 4'b0001;
      exp_ev = (k == 13) ? 4'b0001 : 4'b0000;
      checks++;
      if (bus.key_state !== exp_st || bus.key_release !== exp_ev || bus.key_press !== 4'b0000) begin
        errors++;
        $display("FAIL single_release k=%0d got state=%b rel=%b press=%b expected state=%b rel=%b press=0000",
                 k, bus.key_state, bus.key_release, bus.key_press, exp_st, exp_ev);
      end
    end
    tick(4);
  endtask

  task automatic test_bounce();
    logic [3:0] exp_st, exp_ev;
    for (int i = 0; i < 40; i++) begin
      if (i % 4 == 0) bus.key_i[1] = (((i / 4) % 2) == 0) ? 1'b0 : 1'b1;
      tick(1);
      checks++;
      if ({bus.key_state, bus.key_press, bus.key_release} !== 12'h0) begin
        errors++;
        $display("FAIL bounce_quiet i=%0d got state=%b press=%b rel=%b expected 0",
                 i, bus.key_state, bus.key_press, bus.key_release);
      end
    end
    bus.key_i[1] = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      exp_st = (k >= 13) ? 4'b0010 : 4'b0000;
      exp_ev = (k == 13) ? 4'b0010 : 4'b0000;
      checks++;
      if (bus.key_state !== exp_st || bus.key_press !== exp_ev) begin
        errors++;
        $display("FAIL bounce_settle k=%0d got state=%b press=%b expected state=%b press=%b",
                 k, bus.key_state, bus.key_press, exp_st, exp_ev);
      end
    end
    bus.key_i[1] = 1'b1;
    tick(16);
    checks++;
    if (bus.key_state !== 4'b0000) begin
      errors++;
      $display("FAIL bounce_released got state=%b expected 0000", bus.key_state);
    end
  endtask

  task automatic test_long_repeat();
    logic [3:0] e_long, e_rep, e_rel, e_st;
    bus.key_i[2] = 1'b0;
    tick(13);
    checks++;
    if (bus.key_press !== 4'b0100) begin
      errors++;
      $display("FAIL long_accept got press=%b expected 0100", bus.key_press);
    end
    for (int k = 1; k <= 140; k++) begin
      tick(1);
      e_long = (k == 50) ? 4'b0100 : 4'b0000;
      e_rep  = (k == 70 || k == 90 || k == 110) ? 4'b0100 : 4'b0000;
      e_rel  = (k == 120) ? 4'b0100 : 4'b0000;
      e_st   = (k < 120) ? 4'b0100 : 4'b0000;
      checks++;
      if (bus.key_long !== e_long || bus.key_repeat !== e_rep || bus.key_release !== e_rel || bus.key_state !== e_st) begin
        errors++;
        $display("FAIL long_repeat k=%0d got long=%b rep=%b rel=%b state=%b expected long=%b rep=%b rel=%b state=%b",
                 k, bus.key_long, bus.key_repeat, bus.key_release, bus.key_state, e_long, e_rep, e_rel, e_st);
      end
      if (k == 107) bus.key_i[2] = 1'b1;
    end
  endtask

  task automatic test_release_at_long();
    logic [3:0] e_rel, e_st;
    bus.key_i[3] = 1'b0;
    tick(13);
    checks++;
    if (bus.key_press !== 4'b1000) begin
      errors++;
      $display("FAIL race_accept got press=%b expected 1000", bus.key_press);
    end
    for (int k = 1; k <= 60; k++) begin
      tick(1);
      e_rel = (k == 50) ? 4'b1000 : 4'b0000;
      e_st  = (k < 50) ? 4'b1000 : 4'b0000;
      checks++;
      if (bus.key_long !== 4'b0000 || bus.key_repeat !== 4'b0000 || bus.key_release !== e_rel || bus.key_state !== e_st) begin
        errors++;
        $display("FAIL release_at_long k=%0d got long=%b rep=%b rel=%b state=%b expected long=0000 rep=0000 rel=%b state=%b",
                 k, bus.key_long, bus.key_repeat, bus.key_release, bus.key_state, e_rel, e_st);
      end
      if (k == 37) bus.key_i[3] = 1'b1;
    end
    tick(4);
  endtask

  task automatic test_reset_mid_press();
    logic [3:0] exp_st, exp_ev;
    bus.key_i[0] = 1'b0;
    tick(13);
    checks++;
    if (bus.key_state !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_accept got state=%b expected 0001", bus.key_state);
    end
    tick(5);
    rst = 1'b1;
    tick(1);
    checks++;
    if ({bus.key_state, bus.key_press, bus.key_release, bus.key_long, bus.key_repeat} !== 20'h0) begin
      errors++;
      $display("FAIL midrst_outputs got state=%b press=%b rel=%b long=%b rep=%b expected all 0",
               bus.key_state, bus.key_press, bus.key_release, bus.key_long, bus.key_repeat);
    end
    rst = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      exp_st = (k >= 13) ? 4'b0001 : 4'b0000;
      exp_ev = (k == 13) ? 4'b0001 : 4'b0000;
      checks++;
      if (bus.key_state !== exp_st || bus.key_press !== exp_ev || bus.key_release !== 4'b0000) begin
        errors++;
        $display("FAIL midrst_repress k=%0d got state=%b press=%b rel=%b expected state=%b press=%b rel=0000",
                 k, bus.key_state, bus.key_press, bus.key_release, exp_st, exp_ev);
      end
    end
    bus.key_i[0] = 1'b1;
    tick(16);
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_ev;
    bus.key_i = 4'h0;
    for (int k = 1; k <= 13; k++) begin
      tick(1);
      exp_ev = (k == 13) ? 4'b1111 : 4'b0000;
      checks++;
      if (bus.key_press !== exp_ev) begin
        errors++;
        $display("FAIL all_press k=%0d got press=%b expected %b", k, bus.key_press, exp_ev);
      end
    end
    bus.key_i = 4'hF;
    for (int k = 1; k <= 13; k++) begin
      tick(1);
      exp_ev = (k == 13) ? 4'b1111 : 4'b0000;
      checks++;
      if (bus.key_release !== exp_ev) begin
        errors++;
        $display("FAIL all_release k=%0d got rel=%b expected %b", k, bus.key_release, exp_ev);
      end
    end
    tick(2);
    checks++;
    if (bus.key_state !== 4'b0000) begin
      errors++;
      $display("FAIL all_idle got state=%b expected 0000", bus.key_state);
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.key_i = 4'hF;
    test_reset();
    test_single_press();
    test_bounce();
    test_long_repeat();
    test_release_at_long();
    test_reset_mid_press();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/key_debounce_multi.md
KEY_DEBOUNCE_MULTI -- requirements
Module: key_debounce_multi

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4, meaning number of independent key channels (1..32).
REQ-002 SHALL have parameter CLK_FREQ, default 100_000_000, meaning clk frequency in Hz.
REQ-003 SHALL have parameter DEBOUNCE_MS, default 20, meaning stable time required before a level change is accepted; DEB_CYC = (CLK_FREQ/1000)*DEBOUNCE_MS, minimum 1.
REQ-004 SHALL have parameter LONG_MS, default 1000, meaning hold time from press acceptance to long-press event; LONG_CYC = (CLK_FREQ/1000)*LONG_MS; 0 disables long-press and repeat.
REQ-005 SHALL have parameter REPEAT_MS, default 200, meaning auto-repeat period after long-press; REP_CYC = (CLK_FREQ/1000)*REPEAT_MS; 0 disables repeat.
REQ-006 SHALL have parameter ACTIVE_LOW, default 1, meaning 1 = raw key reads 0 when pressed.
REQ-007 clk  input  1  single clock; all logic on rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 key_i  input  NUM_KEYS  raw asynchronous key levels.
REQ-010 key_state  output  NUM_KEYS  debounced logical state, 1 = pressed, independent of ACTIVE_LOW.
REQ-011 key_press  output  NUM_KEYS  one-cycle pulse on accepted press.
REQ-012 key_release  output  NUM_KEYS  one-cycle pulse on accepted release.
REQ-013 key_long  output  NUM_KEYS  one-cycle pulse when a held key reaches LONG_CYC.
REQ-014 key_repeat  output  NUM_KEYS  one-cycle pulse every REP_CYC while held past long-press.

Function
REQ-015 Each channel SHALL be fully independent and SHALL use its own 3-flop synchronizer, debounce counter, hold counter and FSM; counter widths SHALL be $clog2 of the largest value they reach, minimum 1 bit.
REQ-016 Synchronizer output SHALL be normalised to logical level p = sync[2] XOR ACTIVE_LOW.
REQ-017 While p != key_state, the debounce counter SHALL increment each cycle; when it equals DEB_CYC-1 and p still differs, key_state SHALL take p next edge and the counter SHALL clear.
REQ-018 Any cycle with p == key_state SHALL clear the debounce counter (bounce restarts the window).
REQ-019 Latency: a clean key_i edge SHALL change key_state exactly 3 + DEB_CYC cycles later.
REQ-020 key_press (key_release) SHALL assert in the same cycle key_state rises (falls), for exactly one cycle.
REQ-021 Per-channel FSM states: IDLE (key_state 0), HELD (pressed, before long), LONG (pressed, long reached).
REQ-022 IDLE->HELD on press acceptance, hold counter cleared to 0.
REQ-023 In HELD the hold counter SHALL increment each cycle; on reaching LONG_CYC-1, key_long SHALL pulse and FSM SHALL enter LONG with hold counter cleared; if LONG_CYC = 0, HELD SHALL never exit except by release.
REQ-024 In LONG the hold counter SHALL count modulo REP_CYC; each wrap from REP_CYC-1 to 0 SHALL pulse key_repeat; first repeat SHALL occur REP_CYC cycles after key_long; if REP_CYC = 0, no repeats.
REQ-025 HELD or LONG -> IDLE on release acceptance; hold counter cleared; release in same cycle a long/repeat would fire SHALL suppress the long/repeat pulse and emit only key_release.
REQ-026 key_long and key_repeat SHALL never assert while key_state is 0; at most one of press/release/long/repeat per channel per cycle.
REQ-027 Counters SHALL never wrap unintentionally; debounce counter SHALL not exceed DEB_CYC-1.

Reset
REQ-028 With rst high at a clk edge, all synchronizer flops SHALL load the inactive raw level (ACTIVE_LOW ? 1 : 0), all counters 0, all FSMs IDLE, and key_state, key_press, key_release, key_long, key_repeat SHALL be 0.
REQ-029 Reset mid-press SHALL emit no key_release; a key still held after reset deasserts SHALL be treated as a new press and accepted 3 + DEB_CYC cycles later.

Verification (NUM_KEYS=4, CLK_FREQ=10_000, DEBOUNCE_MS=1, LONG_MS=5, REPEAT_MS=2, ACTIVE_LOW=1: DEB_CYC=10, LONG_CYC=50, REP_CYC=20)
REQ-030 key_i[0] 1->0 cleanly at cycle 0 -> key_state[0]=1 and key_press[0] one-cycle pulse at cycle 13; other channels stay 0.
REQ-031 key_i[1] toggles every 4 cycles for 40 cycles, then held 0 -> no pulses during toggling; key_press[1] exactly 13 cycles after final edge.
REQ-032 key_i[2] held 0 for 120 cycles after acceptance -> key_long[2] at acceptance+50, key_repeat[2] at +70, +90, +110; then release -> key_release[2] 13 cycles after edge, no further repeat.
REQ-033 key_i[3] released so acceptance coincides with the long-press cycle -> only key_release[3], no key_long[3].
REQ-034 key_i[0] held pressed, rst pulsed 1 cycle while key_state[0]=1 -> all outputs 0 after reset, no key_release; key_press[0] re-fires 13 cycles after rst falls.
REQ-035 All four keys pressed in the same cycle -> four key_press bits assert together in one cycle.
